// File: rtl/pll_reset_sequencer_pkg.sv
// Shared state encoding and sizing helpers for the PLL reset sequencer.
package pll_reset_sequencer_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_STABLE    = 2'd1,
      ST_HOLD      = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   // Counter width able to hold max(a,b)-1, never narrower than one bit.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync.sv
// Generic single-bit two-flop synchroniser for asynchronous inputs.
module sync_2ff (
   input  logic clock,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock, sequences the system reset and tracks sticky lock-loss status.
module pll_reset_sequencer
   import pll_reset_sequencer_pkg::*;
#(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RESET_HOLD_CYCLES  = 16,
   parameter int LOSS_CNT_W         = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  pll_lock,
   input  logic                  soft_reset,
   input  logic                  clear_status,
   output logic                  sys_reset,
   output logic                  ready,
   output logic [STATE_W-1:0]    state,
   output logic                  lock_lost,
   output logic [LOSS_CNT_W-1:0] loss_count
);

   localparam int CNT_W = cnt_width(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

   logic                  lock_s;
   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  sys_reset_q, sys_reset_d;
   logic                  ready_q, ready_d;
   logic                  lock_lost_q, lock_lost_d;
   logic [LOSS_CNT_W-1:0] loss_count_q, loss_count_d;
   logic                  run_loss;

   sync_2ff u_lock_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (pll_lock),
      .q       (lock_s)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_WAIT_LOCK;
         cnt_q        <= '0;
         sys_reset_q  <= 1'b1;
         ready_q      <= 1'b0;
         lock_lost_q  <= 1'b0;
         loss_count_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sys_reset_q  <= sys_reset_d;
         ready_q      <= ready_d;
         lock_lost_q  <= lock_lost_d;
         loss_count_q <= loss_count_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sys_reset_d  = sys_reset_q;
      ready_d      = ready_q;
      lock_lost_d  = lock_lost_q;
      loss_count_d = loss_count_q;
      run_loss     = 1'b0;

      if (clear_status) begin
         lock_lost_d  = 1'b0;
         loss_count_d = '0;
      end

      unique case (state_q)
         ST_WAIT_LOCK: begin
            cnt_d = '0;
            if (lock_s) state_d = ST_STABLE;
         end
         ST_STABLE: begin
            if (!lock_s) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (!lock_s) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else if (soft_reset) begin
               cnt_d = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d     = ST_RUN;
               cnt_d       = '0;
               sys_reset_d = 1'b0;
               ready_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (!lock_s) begin
               state_d     = ST_WAIT_LOCK;
               cnt_d       = '0;
               sys_reset_d = 1'b1;
               ready_d     = 1'b0;
               run_loss    = 1'b1;
            end else if (soft_reset) begin
               state_d     = ST_HOLD;
               cnt_d       = '0;
               sys_reset_d = 1'b1;
               ready_d     = 1'b0;
            end
         end
         default: begin
            state_d     = ST_WAIT_LOCK;
            cnt_d       = '0;
            sys_reset_d = 1'b1;
            ready_d     = 1'b0;
         end
      endcase

      // A loss on the same edge as clear_status counts from the cleared value.
      if (run_loss) begin
         lock_lost_d = 1'b1;
         if (loss_count_d != '1) loss_count_d = loss_count_d + LOSS_CNT_W'(1);
      end
   end

   assign sys_reset  = sys_reset_q;
   assign ready      = ready_q;
   assign state      = state_q;
   assign lock_lost  = lock_lost_q;
   assign loss_count = loss_count_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with L=4, H=3, LOSS_CNT_W=2.
module tb_pll_reset_sequencer;

   logic       clock;
   logic       reset_n;
   logic       pll_lock;
   logic       soft_reset;
   logic       clear_status;
   logic       sys_reset;
   logic       ready;
   logic [1:0] state;
   logic       lock_lost;
   logic [1:0] loss_count;

   int checks = 0;
   int errors = 0;

   pll_reset_sequencer #(
      .LOCK_STABLE_CYCLES (4),
      .RESET_HOLD_CYCLES  (3),
      .LOSS_CNT_W         (2)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .pll_lock     (pll_lock),
      .soft_reset   (soft_reset),
      .clear_status (clear_status),
      .sys_reset    (sys_reset),
      .ready        (ready),
      .state        (state),
      .lock_lost    (lock_lost),
      .loss_count   (loss_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // From WAIT_LOCK with both sync stages low: lock, then RUN at edge 10.
   task automatic go_run();
      pll_lock = 1'b1;
      tick(10);
   endtask

   // RUN loss: FSM reacts on the third edge after pll_lock drops.
   task automatic drop_lock();
      pll_lock = 1'b0;
      tick(3);
   endtask

   initial begin
      reset_n      = 1'b0;
      pll_lock     = 1'b1;
      soft_reset   = 1'b0;
      clear_status = 1'b0;

      // Power-up
      tick(5);
      chk("rst_sys_reset", int'(sys_reset), 1);
      chk("rst_ready", int'(ready), 0);
      chk("rst_state", int'(state), 0);
      chk("rst_lock_lost", int'(lock_lost), 0);
      chk("rst_loss_count", int'(loss_count), 0);
      reset_n = 1'b1;
      tick(2);
      chk("pu_wait_e2", int'(state), 0);
      tick(1);
      chk("pu_stable_e3", int'(state), 1);
      tick(4);
      chk("pu_hold_e7", int'(state), 2);
      tick(2);
      chk("pu_sysrst_e9", int'(sys_reset), 1);
      chk("pu_ready_e9", int'(ready), 0);
      tick(1);
      chk("pu_state_e10", int'(state), 3);
      chk("pu_sysrst_e10", int'(sys_reset), 0);
      chk("pu_ready_e10", int'(ready), 1);

      // Lock drop in RUN
      pll_lock = 1'b0;
      tick(2);
      chk("loss_still_run_e2", int'(state), 3);
      tick(1);
      chk("loss_state_e3", int'(state), 0);
      chk("loss_sysrst_e3", int'(sys_reset), 1);
      chk("loss_ready_e3", int'(ready), 0);
      chk("loss_lost_e3", int'(lock_lost), 1);
      chk("loss_cnt_e3", int'(loss_count), 1);
      pll_lock = 1'b1;
      tick(9);
      chk("relock_hold_e9", int'(state), 2);
      tick(1);
      chk("relock_run_e10", int'(state), 3);

      // Second loss then clear
      drop_lock();
      chk("loss2_cnt", int'(loss_count), 2);
      clear_status = 1'b1;
      tick(1);
      clear_status = 1'b0;
      chk("clr_lost", int'(lock_lost), 0);
      chk("clr_cnt", int'(loss_count), 0);

      // Drop mid-STABLE
      pll_lock = 1'b1;
      tick(3);
      chk("stb_enter", int'(state), 1);
      pll_lock = 1'b0;
      tick(2);
      pll_lock = 1'b1;
      tick(1);
      chk("stb_drop_state", int'(state), 0);
      chk("stb_drop_cnt", int'(loss_count), 0);
      chk("stb_drop_lost", int'(lock_lost), 0);
      tick(2);
      chk("stb_reenter", int'(state), 1);
      tick(3);
      chk("stb_restart_still", int'(state), 1);
      tick(1);
      chk("stb_restart_hold", int'(state), 2);

      // Drop mid-HOLD (would reach RUN on h3 without the drop)
      pll_lock = 1'b0;
      tick(2);
      pll_lock = 1'b1;
      tick(1);
      chk("hold_drop_state", int'(state), 0);
      chk("hold_drop_sysrst", int'(sys_reset), 1);
      chk("hold_drop_cnt", int'(loss_count), 0);
      tick(6);
      chk("hold_relock_hold", int'(state), 2);
      tick(3);
      chk("hold_relock_run", int'(state), 3);

      // soft_reset in RUN: exactly H cycles of reset
      soft_reset = 1'b1;
      tick(1);
      soft_reset = 1'b0;
      chk("soft_run_state", int'(state), 2);
      chk("soft_run_sysrst", int'(sys_reset), 1);
      chk("soft_run_ready", int'(ready), 0);
      tick(2);
      chk("soft_run_sysrst_c3", int'(sys_reset), 1);
      tick(1);
      chk("soft_run_back", int'(state), 3);
      chk("soft_run_sysrst_off", int'(sys_reset), 0);

      // soft_reset in HOLD restarts the hold count
      soft_reset = 1'b1;
      tick(1);
      soft_reset = 1'b0;
      tick(1);
      soft_reset = 1'b1;
      tick(1);
      soft_reset = 1'b0;
      tick(2);
      chk("soft_hold_restart", int'(state), 2);
      tick(1);
      chk("soft_hold_run", int'(state), 3);

      // soft_reset in WAIT_LOCK is ignored
      drop_lock();
      chk("wl_cnt", int'(loss_count), 1);
      soft_reset = 1'b1;
      tick(1);
      soft_reset = 1'b0;
      chk("wl_soft_state", int'(state), 0);
      tick(1);
      chk("wl_soft_state2", int'(state), 0);

      // Saturation
      clear_status = 1'b1;
      tick(1);
      clear_status = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         go_run();
         chk("sat_run", int'(state), 3);
         drop_lock();
         chk("sat_cnt", int'(loss_count), (i > 3) ? 3 : i);
      end
      chk("sat_lost", int'(lock_lost), 1);

      // clear_status on the same edge as a loss
      go_run();
      pll_lock = 1'b0;
      tick(2);
      clear_status = 1'b1;
      tick(1);
      clear_status = 1'b0;
      chk("clr_loss_cnt", int'(loss_count), 1);
      chk("clr_loss_lost", int'(lock_lost), 1);
      chk("clr_loss_state", int'(state), 0);

      // Asynchronous reset mid-HOLD
      pll_lock = 1'b1;
      tick(8);
      chk("ar_in_hold", int'(state), 2);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_state", int'(state), 0);
      chk("ar_sysrst", int'(sys_reset), 1);
      chk("ar_ready", int'(ready), 0);
      chk("ar_lost", int'(lock_lost), 0);
      chk("ar_cnt", int'(loss_count), 0);
      tick(2);
      reset_n = 1'b1;
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
